// File: rtl/reg_err_logger.sv
//==============================================================================
// Module   : reg_err_logger
// Function : Logs writeback register-file check mismatches into a show-ahead
//            FIFO, keeps saturating statistics, a first-error record and halt.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_err_logger #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_valid,
  input  logic              reg_file_error,
  input  logic [ADDR_W-1:0] chk_ws,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              clear,
  input  logic              halt_en,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_ws,
  output logic [DATA_W-1:0] log_data,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  chk_count,
  output logic              overflow,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_ws,
  output logic              halt_req
);

  localparam int                c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]  c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  logic [ADDR_W-1:0] r_mem_ws   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [c_PTR_W:0]  r_wr_ptr;
  logic [c_PTR_W:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_err_count;
  logic [CNT_W-1:0]  r_chk_count;
  logic              r_overflow;
  logic              r_first_err_valid;
  logic [ADDR_W-1:0] r_first_err_ws;
  state_t            r_state;
  logic              r_halt_req;

  logic w_event;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_event = chk_valid & reg_file_error;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop   = !w_empty & log_ready & !clear;
  assign w_push  = w_event & (!w_full | w_pop) & !clear;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ws[r_wr_ptr[c_PTR_W-1:0]]   <= chk_ws;
      r_mem_data[r_wr_ptr[c_PTR_W-1:0]] <= chk_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_err_count       <= '0;
      r_chk_count       <= '0;
      r_overflow        <= 1'b0;
      r_first_err_valid <= 1'b0;
      r_first_err_ws    <= '0;
    end else if (clear) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_err_count       <= '0;
      r_chk_count       <= '0;
      r_overflow        <= 1'b0;
      r_first_err_valid <= 1'b0;
      r_first_err_ws    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (chk_valid && r_chk_count != c_CNT_MAX) r_chk_count <= r_chk_count + c_CNT_ONE;
      if (w_event && r_err_count != c_CNT_MAX)   r_err_count <= r_err_count + c_CNT_ONE;
      if (w_event && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_event && !r_first_err_valid) begin
        r_first_err_valid <= 1'b1;
        r_first_err_ws    <= chk_ws;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_halt_req <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_RUN;
      r_halt_req <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_event && halt_en) begin
            r_state    <= ST_HALTED;
            r_halt_req <= 1'b1;
          end
        end
        ST_HALTED: r_halt_req <= 1'b1;
        default: begin
          r_state    <= ST_RUN;
          r_halt_req <= 1'b0;
        end
      endcase
    end
  end

  // Head data is masked while empty so stale storage never shows on the port.
  assign log_valid       = !w_empty;
  assign log_ws          = w_empty ? '0 : r_mem_ws[r_rd_ptr[c_PTR_W-1:0]];
  assign log_data        = w_empty ? '0 : r_mem_data[r_rd_ptr[c_PTR_W-1:0]];
  assign err_count       = r_err_count;
  assign chk_count       = r_chk_count;
  assign overflow        = r_overflow;
  assign first_err_valid = r_first_err_valid;
  assign first_err_ws    = r_first_err_ws;
  assign halt_req        = r_halt_req;

endmodule

`default_nettype wire

// File: tb/tb_reg_err_logger.sv
//==============================================================================
// Module   : tb_reg_err_logger
// Function : Directed self-checking bench for reg_err_logger.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_err_logger;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              chk_valid;
  logic              reg_file_error;
  logic [ADDR_W-1:0] chk_ws;
  logic [DATA_W-1:0] chk_data;
  logic              clear;
  logic              halt_en;
  logic              log_valid;
  logic              log_ready;
  logic [ADDR_W-1:0] log_ws;
  logic [DATA_W-1:0] log_data;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  chk_count;
  logic              overflow;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_ws;
  logic              halt_req;

  int r_vectors;
  int r_miscompares;

  reg_err_logger #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chk_valid      (chk_valid),
    .reg_file_error (reg_file_error),
    .chk_ws         (chk_ws),
    .chk_data       (chk_data),
    .clear          (clear),
    .halt_en        (halt_en),
    .log_valid      (log_valid),
    .log_ready      (log_ready),
    .log_ws         (log_ws),
    .log_data       (log_data),
    .err_count      (err_count),
    .chk_count      (chk_count),
    .overflow       (overflow),
    .first_err_valid(first_err_valid),
    .first_err_ws   (first_err_ws),
    .halt_req       (halt_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_vectors++;
    assert (obs === exp)
    else begin
      r_miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_chk(input logic v, input logic e, input logic [ADDR_W-1:0] ws,
                           input logic [DATA_W-1:0] d);
    chk_valid      = v;
    reg_file_error = e;
    chk_ws         = ws;
    chk_data       = d;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    r_vectors     = 0;
    r_miscompares = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    halt_en       = 1'b0;
    log_ready     = 1'b0;
    drive_chk(1'b0, 1'b0, '0, '0);

    // Reset state
    #12;
    check("rst_log_valid", log_valid, 0);
    check("rst_log_ws", log_ws, 0);
    check("rst_log_data", log_data, 0);
    check("rst_err_count", err_count, 0);
    check("rst_chk_count", chk_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_first_valid", first_err_valid, 0);
    check("rst_first_ws", first_err_ws, 0);
    check("rst_halt_req", halt_req, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_log_valid", log_valid, 0);
    check("idle_err_count", err_count, 0);
    check("idle_chk_count", chk_count, 0);

    // Single mismatch
    drive_chk(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    drive_chk(1'b0, 1'b0, '0, '0);
    check("single_log_valid", log_valid, 1);
    check("single_log_ws", log_ws, 7);
    check("single_log_data", log_data, 32'hDEADBEEF);
    check("single_err_count", err_count, 1);
    check("single_chk_count", chk_count, 1);
    check("single_first_valid", first_err_valid, 1);
    check("single_first_ws", first_err_ws, 7);
    check("single_halt_req", halt_req, 0);
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    check("single_popped", log_valid, 0);

    // Mixed checks after a clear
    pulse_clear();
    check("clr_first_valid", first_err_valid, 0);
    drive_chk(1'b1, 1'b0, 5'd1, 32'h1000_0001); tick();
    drive_chk(1'b1, 1'b1, 5'd3, 32'h1000_0003); tick();
    drive_chk(1'b1, 1'b0, 5'd5, 32'h1000_0005); tick();
    drive_chk(1'b1, 1'b1, 5'd9, 32'h1000_0009); tick();
    drive_chk(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF); tick();  // error ignored without strobe
    drive_chk(1'b0, 1'b0, '0, '0);
    check("mixed_chk_count", chk_count, 4);
    check("mixed_err_count", err_count, 2);
    check("mixed_first_ws", first_err_ws, 3);
    check("mixed_head0_ws", log_ws, 3);
    check("mixed_head0_data", log_data, 32'h1000_0003);
    log_ready = 1'b1;
    tick();
    check("mixed_head1_ws", log_ws, 9);
    check("mixed_head1_data", log_data, 32'h1000_0009);
    tick();
    log_ready = 1'b0;
    check("mixed_empty", log_valid, 0);

    // Overflow: 10 events into an 8-deep log with no consumer
    pulse_clear();
    for (int i = 0; i < 10; i++) begin
      drive_chk(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i * 32'h11));
      tick();
    end
    check("ovf_err_count", err_count, 10);
    check("ovf_flag", overflow, 1);
    check("ovf_head_ws", log_ws, 0);
    check("ovf_first_ws", first_err_ws, 0);
    // Full with a simultaneous pop: nothing is dropped
    drive_chk(1'b1, 1'b1, 5'd20, 32'hCAFE_0020);
    log_ready = 1'b1;
    tick();
    drive_chk(1'b0, 1'b0, '0, '0);
    check("ovf_pushpop_err", err_count, 11);
    for (int i = 1; i < 8; i++) begin
      check("drain_valid", log_valid, 1);
      check("drain_ws", log_ws, i);
      check("drain_data", log_data, i * 32'h11);
      tick();
    end
    check("drain_last_ws", log_ws, 20);
    check("drain_last_data", log_data, 32'hCAFE_0020);
    tick();
    log_ready = 1'b0;
    check("drain_empty", log_valid, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Halt on error, sticky past halt_en, logging continues, clear releases
    halt_en = 1'b1;
    drive_chk(1'b1, 1'b1, 5'd4, 32'h0000_0044);
    check("halt_before_edge", halt_req, 0);
    tick();
    drive_chk(1'b0, 1'b0, '0, '0);
    check("halt_set", halt_req, 1);
    halt_en = 1'b0;
    repeat (3) tick();
    check("halt_sticky", halt_req, 1);
    drive_chk(1'b1, 1'b1, 5'd6, 32'h0000_0066);
    tick();
    drive_chk(1'b0, 1'b0, '0, '0);
    check("halt_err_count", err_count, 13);
    check("halt_chk_count", chk_count, 13);
    pulse_clear();
    check("hclr_halt_req", halt_req, 0);
    check("hclr_err_count", err_count, 0);
    check("hclr_chk_count", chk_count, 0);
    check("hclr_log_valid", log_valid, 0);
    check("hclr_overflow", overflow, 0);
    check("hclr_first_valid", first_err_valid, 0);

    // Clear colliding with an event: the event is discarded
    halt_en = 1'b1;
    clear   = 1'b1;
    drive_chk(1'b1, 1'b1, 5'd2, 32'h0000_0022);
    tick();
    clear = 1'b0;
    drive_chk(1'b0, 1'b0, '0, '0);
    check("coll_err_count", err_count, 0);
    check("coll_chk_count", chk_count, 0);
    check("coll_log_valid", log_valid, 0);
    check("coll_first_valid", first_err_valid, 0);
    check("coll_halt_req", halt_req, 0);
    halt_en = 1'b0;

    // Event into an empty log with the consumer ready: entry is kept
    log_ready = 1'b1;
    drive_chk(1'b1, 1'b1, 5'd11, 32'h0000_00BB);
    tick();
    log_ready = 1'b0;
    drive_chk(1'b0, 1'b0, '0, '0);
    check("emptyrdy_valid", log_valid, 1);
    check("emptyrdy_ws", log_ws, 11);
    check("emptyrdy_first_ws", first_err_ws, 11);

    // Asynchronous reset mid-cycle discards everything at once
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_log_valid", log_valid, 0);
    check("areset_err_count", err_count, 0);
    check("areset_chk_count", chk_count, 0);
    check("areset_first_valid", first_err_valid, 0);
    check("areset_first_ws", first_err_ws, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", log_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_err_logger.md
Name: reg_err_logger

Overview:
- Downstream consumer of the writeback register-file checker's `reg_file_error` result.
- Qualifies each check with a strobe and logs every mismatching writeback (destination register and ALU data) into a small show-ahead FIFO for debug readout.
- Keeps saturating error statistics and a sticky first-error record.
- Can request a pipeline halt on the first mismatch.

Parameters:
- DEPTH, 8, number of FIFO log entries (power of two, ≥2)
- CNT_W, 16, width of the error and check counters
- DATA_W, 32, width of the logged writeback data
- ADDR_W, 5, width of the register specifier

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- chk_valid  input  1  check-result strobe: high the cycle after an S3 cycle with write enable, i.e. when `reg_file_error` is freshly updated
- reg_file_error  input  1  checker result; meaningful only when chk_valid=1
- chk_ws  input  ADDR_W  destination register of the checked write, aligned with chk_valid
- chk_data  input  DATA_W  ALU writeback data of the checked write, aligned with chk_valid
- clear  input  1  synchronous clear of log, counters, flags and halt state
- halt_en  input  1  enables halt-on-error
- log_valid  output  1  FIFO head entry is valid
- log_ready  input  1  consumer accepts the head entry
- log_ws  output  ADDR_W  head entry register specifier
- log_data  output  DATA_W  head entry data
- err_count  output  CNT_W  number of mismatch events (saturating)
- chk_count  output  CNT_W  number of qualified checks (saturating)
- overflow  output  1  sticky: a mismatch was dropped because the FIFO was full
- first_err_valid  output  1  sticky: first-error record holds data
- first_err_ws  output  ADDR_W  register of the first mismatch since reset/clear
- halt_req  output  1  pipeline halt request

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; FIFO empty; pointers 0; FSM = RUN.
  - Reset mid-operation discards all log content immediately.
- Event definitions:
  - check = chk_valid.
  - event = chk_valid & reg_file_error.
  - Inputs are sampled on the rising edge of clk.
- Counters:
  - chk_count increments on every check.
  - err_count increments on every event, including dropped ones.
  - Both saturate at 2^CNT_W-1 and never wrap.
- FIFO:
  - Show-ahead: log_valid = !empty; log_ws/log_data reflect the head combinationally from storage.
  - Pop when log_valid & log_ready; the next entry (or empty) is visible the following cycle.
  - Push on event when not full, or when full and a pop occurs in the same cycle (no drop).
  - Push on event when full with no pop: entry dropped, overflow set.
  - Empty with event and log_ready=1: no pop occurs (log_valid was 0); entry pushed; log_valid=1 next cycle.
  - Latency: event at edge N → entry visible (log_valid=1) after edge N, i.e. cycle N+1.
  - Pointers wrap modulo DEPTH; occupancy is tracked with an extra pointer bit or a count (0..DEPTH).
- First error:
  - On the first event while first_err_valid=0, capture chk_ws and set first_err_valid.
  - Later events do not modify the record.
- Halt FSM:
  - RUN: halt_req=0. On event with halt_en=1 → HALTED.
  - HALTED: halt_req=1, registered (asserted the cycle after the event). Stays HALTED regardless of halt_en until clear → RUN.
  - Logging and counting continue while HALTED.
- Clear (synchronous, highest priority after reset):
  - Empties the FIFO; zeros counters; clears overflow and first_err_valid; FSM → RUN.
  - A check, event or pop coincident with clear is discarded.
- chk_ws/chk_data are ignored when chk_valid=0; reg_file_error is ignored when chk_valid=0.

Test Plan:
- Reset then idle: rst_n low mid-cycle → all outputs 0 immediately; after release, 10 idle cycles keep log_valid=0 and both counts=0.
- Single mismatch: chk_valid=1, reg_file_error=1, chk_ws=5'd7, chk_data=32'hDEADBEEF with log_ready=0 → next cycle log_valid=1, log_ws=7, log_data=DEADBEEF, err_count=1, chk_count=1, first_err_ws=7.
- Mixed checks: 4 checks with errors on the 2nd and 4th (ws=3, ws=9) → chk_count=4, err_count=2, FIFO order 3 then 9, first_err_ws=3.
- Overflow with DEPTH=8 and log_ready=0: 10 consecutive events → 8 entries held, overflow=1, err_count=10. Then an event on a full FIFO with log_ready=1 → no drop, occupancy stays 8.
- Halt: halt_en=1, event at edge N → halt_req=1 from cycle N+1. Deassert halt_en → halt_req stays 1. Pulse clear → halt_req=0, counts 0, log_valid=0, overflow=0.
- Clear vs event collision: clear=1 and an event in the same cycle → next cycle err_count=0, log_valid=0, first_err_valid=0.
